shift_chain_sequencer: RTL and testbench

Controller that drives the team's serial-in/serial-out shift chain. It accepts parallel words through a valid/ready handshake and serialises each word MSB-first onto the chain input. It waits out the chain's fixed pipeline latency, deserialises the returning bit stream into a parallel word, and then enforces an idle gap before accepting the next word. It sits between a parallel producer/consumer and one fixed-latency serial chain.

---
 rtl/shift_chain_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_shift_chain_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_sequencer.sv
// -----------------------------------------------------------------------------
// shift_chain_sequencer
//
// Drives one fixed-latency serial-in/serial-out shift chain from a parallel
// valid/ready producer. An accepted word is shifted out MSB-first on
// shift_out, the chain's pipeline latency is waited out, the returning bits
// on shift_in are reassembled into rx_data, and an idle gap is inserted
// before the next word is accepted.
//
// Parameters:
//   DATA_WIDTH    bits per word (>= 2)
//   CHAIN_LATENCY edges from the chain sampling a bit to it showing on shift_in
//   GAP_CYCLES    idle cycles after each word before tx_ready re-asserts
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   tx_data    word to serialise, sampled only on tx_valid & tx_ready
//   tx_valid   producer has a word
//   tx_ready   sequencer can accept a word (registered)
//   shift_out  serial bit towards the chain input (registered)
//   shift_en   high while a data bit is presented on shift_out
//   shift_in   serial bit returning from the chain output
//   rx_data    last reassembled word, held until the next completion
//   rx_valid   one-cycle pulse when rx_data is updated
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module shift_chain_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int CHAIN_LATENCY = 4,
    parameter int GAP_CYCLES    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  shift_out,
    output logic                  shift_en,
    input  logic                  shift_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int MAX_A = (DATA_WIDTH > CHAIN_LATENCY) ? DATA_WIDTH : CHAIN_LATENCY;
    localparam int MAX_V = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W = $clog2(MAX_V + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(CHAIN_LATENCY);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t                  state_r;
    logic [DATA_WIDTH-2:0]   tx_sr_r;     // bits still to be sent, next one at the top
    logic [CNT_W-1:0]        bit_cnt_r;   // bits left to present after the current one
    logic [CNT_W-1:0]        cap_dly_r;   // edges left before sampling starts
    logic                    cap_act_r;   // sampling window open
    logic [CNT_W-1:0]        cap_cnt_r;   // samples already taken
    logic [CNT_W-1:0]        gap_cnt_r;   // gap cycles left after the current one
    logic [DATA_WIDTH-2:0]   cap_r;       // samples taken so far, newest at the bottom

    logic [DATA_WIDTH-1:0]   cap_next_s;
    logic [DATA_WIDTH-1:0]   tx_shift_s;
    logic                    cap_done_s;

    // Next capture word, next transmit shift value and last-sample detection.
    always_comb begin
        cap_next_s = {cap_r, shift_in};
        tx_shift_s = {tx_sr_r, 1'b0};
        cap_done_s = 1'b0;
        if (cap_act_r && (cap_cnt_r == LAST_BIT)) begin
            cap_done_s = 1'b1;
        end else begin
            cap_done_s = 1'b0;
        end
    end

    // Sequencer FSM, capture timing and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            tx_sr_r   <= {(DATA_WIDTH-1){1'b0}};
            bit_cnt_r <= CNT_ZERO;
            cap_dly_r <= CNT_ZERO;
            cap_act_r <= 1'b0;
            cap_cnt_r <= CNT_ZERO;
            gap_cnt_r <= CNT_ZERO;
            cap_r     <= {(DATA_WIDTH-1){1'b0}};
            tx_ready  <= 1'b0;
            shift_out <= 1'b0;
            shift_en  <= 1'b0;
            rx_data   <= {DATA_WIDTH{1'b0}};
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            // Capture runs on its own timer so it can overlap SHIFT when the
            // chain is shorter than the word.
            if (cap_act_r) begin
                cap_r     <= cap_next_s[DATA_WIDTH-2:0];
                cap_cnt_r <= cap_cnt_r + CNT_ONE;
            end else if (cap_dly_r != CNT_ZERO) begin
                if (cap_dly_r == CNT_ONE) begin
                    cap_act_r <= 1'b1;
                end else begin
                    cap_act_r <= 1'b0;
                end
                cap_dly_r <= cap_dly_r - CNT_ONE;
            end else begin
                cap_act_r <= cap_act_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (tx_ready && tx_valid) begin
                        tx_sr_r   <= tx_data[DATA_WIDTH-2:0];
                        shift_out <= tx_data[DATA_WIDTH-1];
                        shift_en  <= 1'b1;
                        bit_cnt_r <= LAST_BIT;
                        cap_dly_r <= LAT_LOAD;
                        cap_act_r <= (CHAIN_LATENCY == 0);
                        cap_cnt_r <= CNT_ZERO;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else begin
                        tx_ready  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_r == CNT_ZERO) begin
                        shift_out <= 1'b0;
                        shift_en  <= 1'b0;
                        state_r   <= ST_DRAIN;
                    end else begin
                        shift_out <= tx_shift_s[DATA_WIDTH-1];
                        tx_sr_r   <= tx_shift_s[DATA_WIDTH-2:0];
                        bit_cnt_r <= bit_cnt_r - CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    // Left only by the completion below.
                    state_r <= ST_DRAIN;
                end
                ST_GAP: begin
                    if (gap_cnt_r == CNT_ZERO) begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    shift_out <= 1'b0;
                    shift_en  <= 1'b0;
                    tx_ready  <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase

            // Completion: last sample lands at end of SHIFT (zero latency) or
            // inside DRAIN, and takes precedence over the state set above.
            if (cap_done_s) begin
                rx_data   <= cap_next_s;
                rx_valid  <= 1'b1;
                cap_act_r <= 1'b0;
                cap_cnt_r <= CNT_ZERO;
                if (GAP_CYCLES > 0) begin
                    gap_cnt_r <= GAP_LAST;
                    state_r   <= ST_GAP;
                end else begin
                    tx_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            end else begin
                rx_data <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_shift_chain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_chain_sequencer
//
// Three sequencer instances with different shapes:
//   0: W=8,  L=4, GAP=1 behind a 4-flop chain
//   1: W=8,  L=0, GAP=0 with direct loopback
//   2: W=16, L=4, GAP=3 behind a 4-flop chain
// A transaction-level reference model predicts every output from the accept
// edge k of the in-flight word: shift window k..k+W-1, completion at k+W+L,
// ready again at k+W+L+GAP. All outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_shift_chain_sequencer;

    logic        clock;
    logic        reset_n;
    logic [15:0] tx_data_a  [3];
    logic        tx_valid_a [3];
    logic [1:0]  mode_a     [3];   // 0 loopback, 2 force 0, 3 force 1
    logic        tx_ready_a [3];
    logic        shift_out_a[3];
    logic        shift_en_a [3];
    logic        shift_in_a [3];
    logic        rx_valid_a [3];
    logic        busy_a     [3];
    logic [15:0] rx_a       [3];
    logic [7:0]  rx0, rx1;
    logic [15:0] rx2;
    logic [3:0]  ch0_r, ch2_r;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          t_m;
    int          k_m        [3];
    int          ready_at_m [3];
    int          acc_cnt_m  [3] = '{0, 0, 0};
    bit          act_m      [3];
    logic [15:0] word_m     [3];
    logic [15:0] expw_m     [3];
    logic [15:0] exp_rx_m   [3];

    function automatic int pw(input int i);
        case (i)
            2:       pw = 16;
            default: pw = 8;
        endcase
    endfunction

    function automatic int pl(input int i);
        case (i)
            1:       pl = 0;
            default: pl = 4;
        endcase
    endfunction

    function automatic int pg(input int i);
        case (i)
            0:       pg = 1;
            1:       pg = 0;
            default: pg = 3;
        endcase
    endfunction

    function automatic logic [15:0] mask(input int i);
        mask = (i == 2) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] exp_word(input int i, input logic [15:0] w, input logic [1:0] m);
        case (m)
            2'd3:    exp_word = mask(i);
            2'd2:    exp_word = 16'h0000;
            default: exp_word = w & mask(i);
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    shift_chain_sequencer #(.DATA_WIDTH(8), .CHAIN_LATENCY(4), .GAP_CYCLES(1)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data_a[0][7:0]), .tx_valid(tx_valid_a[0]),
        .tx_ready(tx_ready_a[0]), .shift_out(shift_out_a[0]), .shift_en(shift_en_a[0]),
        .shift_in(shift_in_a[0]), .rx_data(rx0), .rx_valid(rx_valid_a[0]), .busy(busy_a[0]));

    shift_chain_sequencer #(.DATA_WIDTH(8), .CHAIN_LATENCY(0), .GAP_CYCLES(0)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data_a[1][7:0]), .tx_valid(tx_valid_a[1]),
        .tx_ready(tx_ready_a[1]), .shift_out(shift_out_a[1]), .shift_en(shift_en_a[1]),
        .shift_in(shift_in_a[1]), .rx_data(rx1), .rx_valid(rx_valid_a[1]), .busy(busy_a[1]));

    shift_chain_sequencer #(.DATA_WIDTH(16), .CHAIN_LATENCY(4), .GAP_CYCLES(3)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data_a[2]), .tx_valid(tx_valid_a[2]),
        .tx_ready(tx_ready_a[2]), .shift_out(shift_out_a[2]), .shift_en(shift_en_a[2]),
        .shift_in(shift_in_a[2]), .rx_data(rx2), .rx_valid(rx_valid_a[2]), .busy(busy_a[2]));

    assign rx_a[0] = {8'h00, rx0};
    assign rx_a[1] = {8'h00, rx1};
    assign rx_a[2] = rx2;

    assign shift_in_a[0] = (mode_a[0] == 2'd0) ? ch0_r[3]       : mode_a[0][0];
    assign shift_in_a[1] = (mode_a[1] == 2'd0) ? shift_out_a[1] : mode_a[1][0];
    assign shift_in_a[2] = (mode_a[2] == 2'd0) ? ch2_r[3]       : mode_a[2][0];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 4-flop external chains
    always @(posedge clock) begin
        ch0_r <= {ch0_r[2:0], shift_out_a[0]};
        ch2_r <= {ch2_r[2:0], shift_out_a[2]};
    end

    // Transaction-level reference model: t_m counts edges since reset release.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            t_m <= 0;
            for (int i = 0; i < 3; i++) begin
                act_m[i]      <= 1'b0;
                ready_at_m[i] <= 1;
                exp_rx_m[i]   <= 16'h0000;
            end
        end else begin
            t_m <= t_m + 1;
            for (int i = 0; i < 3; i++) begin
                if (tx_valid_a[i] && (t_m >= ready_at_m[i])) begin
                    k_m[i]        <= t_m + 1;
                    ready_at_m[i] <= t_m + 1 + pw(i) + pl(i) + pg(i);
                    act_m[i]      <= 1'b1;
                    word_m[i]     <= tx_data_a[i] & mask(i);
                    expw_m[i]     <= exp_word(i, tx_data_a[i], mode_a[i]);
                    acc_cnt_m[i]  <= acc_cnt_m[i] + 1;
                end
                if (act_m[i] && (t_m + 1 == k_m[i] + pw(i) + pl(i)))
                    exp_rx_m[i] <= expw_m[i];
            end
        end
    end

    // Compare every output of every instance against the model.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            bit e_sen;
            bit e_sout;
            e_sen  = act_m[i] && (t_m >= k_m[i]) && (t_m < k_m[i] + pw(i));
            e_sout = e_sen ? word_m[i][pw(i) - 1 - (t_m - k_m[i])] : 1'b0;
            check_eq($sformatf("i%0d tx_ready", i), 32'(tx_ready_a[i]), 32'(t_m >= ready_at_m[i]));
            check_eq($sformatf("i%0d busy", i), 32'(busy_a[i]), 32'(act_m[i] && (t_m < ready_at_m[i])));
            check_eq($sformatf("i%0d shift_en", i), 32'(shift_en_a[i]), 32'(e_sen));
            check_eq($sformatf("i%0d shift_out", i), 32'(shift_out_a[i]), 32'(e_sout));
            check_eq($sformatf("i%0d rx_valid", i), 32'(rx_valid_a[i]),
                     32'(act_m[i] && (t_m == k_m[i] + pw(i) + pl(i))));
            check_eq($sformatf("i%0d rx_data", i), 32'(rx_a[i]), 32'(exp_rx_m[i]));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_acc(input int i);
        int c0;
        int n;
        c0 = acc_cnt_m[i];
        n  = 0;
        while ((acc_cnt_m[i] == c0) && (n < 200)) begin
            step();
            n++;
        end
        if (n >= 200) check_eq($sformatf("i%0d accept timeout", i), 32'(acc_cnt_m[i]), 32'(c0 + 1));
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((t_m < ready_at_m[i]) && (n < 300)) begin
            step();
            n++;
        end
        if (n >= 300) check_eq($sformatf("i%0d idle timeout", i), 32'(t_m), 32'(ready_at_m[i]));
    endtask

    task automatic send(input int i, input logic [15:0] w, input logic [1:0] m);
        mode_a[i]     = m;
        tx_data_a[i]  = w;
        tx_valid_a[i] = 1'b1;
        wait_acc(i);
        tx_valid_a[i] = 1'b0;
    endtask

    initial begin
        int k1;
        int k2;
        for (int i = 0; i < 3; i++) begin
            tx_data_a[i]  = 16'h0000;
            tx_valid_a[i] = 1'b0;
            mode_a[i]     = 2'd0;
        end
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;

        // reset in the middle of shifting 0x3C
        send(0, 16'h003C, 2'd0);
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_eq("rst tx_ready", 32'(tx_ready_a[0]), 32'd0);
        check_eq("rst shift_en", 32'(shift_en_a[0]), 32'd0);
        check_eq("rst shift_out", 32'(shift_out_a[0]), 32'd0);
        check_eq("rst busy", 32'(busy_a[0]), 32'd0);
        check_eq("rst rx_valid", 32'(rx_valid_a[0]), 32'd0);
        check_eq("rst rx_data", 32'(rx_a[0]), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // 0xA5 loopback, garbage on tx_valid/tx_data while busy
        send(0, 16'h00A5, 2'd0);
        while (t_m < ready_at_m[0]) begin
            tx_valid_a[0] = 1'($urandom_range(0, 1));
            tx_data_a[0]  = 16'h00FF;
            step();
        end
        tx_valid_a[0] = 1'b0;
        check_eq("a5 rx_data", 32'(rx_a[0]), 32'h00A5);

        // chain output forced, result independent of the sent word
        send(0, 16'h0000, 2'd3);
        wait_idle(0);
        check_eq("force1 rx_data", 32'(rx_a[0]), 32'h00FF);
        send(0, 16'h00FF, 2'd2);
        wait_idle(0);
        check_eq("force0 rx_data", 32'(rx_a[0]), 32'h0000);
        repeat (5) step();
        check_eq("rx hold", 32'(rx_a[0]), 32'h0000);
        mode_a[0] = 2'd0;

        // back-to-back, zero latency, zero gap
        tx_data_a[1]  = 16'h0081;
        tx_valid_a[1] = 1'b1;
        wait_acc(1);
        k1 = k_m[1];
        tx_data_a[1] = 16'h007E;
        wait_acc(1);
        k2 = k_m[1];
        tx_valid_a[1] = 1'b0;
        check_eq("b2b spacing", 32'(k2 - k1), 32'd9);
        check_eq("b2b first rx", 32'(rx_a[1]), 32'h0081);
        wait_idle(1);
        check_eq("b2b second rx", 32'(rx_a[1]), 32'h007E);

        // 16-bit word through the 4-flop chain with a 3-cycle gap
        send(2, 16'hBEEF, 2'd0);
        wait_idle(2);
        check_eq("beef rx_data", 32'(rx_a[2]), 32'hBEEF);

        // random traffic on all three instances, loopback
        repeat (400) begin
            for (int i = 0; i < 3; i++) begin
                tx_valid_a[i] = ($urandom_range(0, 3) != 0);
                tx_data_a[i]  = 16'($urandom) & mask(i);
            end
            step();
        end
        for (int i = 0; i < 3; i++) tx_valid_a[i] = 1'b0;
        for (int i = 0; i < 3; i++) wait_idle(i);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
